// File: rtl/qea_state_reader.sv
// Streams the QEA state RAM out as valid/ready words; reads start once the QEA completes, RD_LATENCY-cycle RAM, 4-deep output FIFO.
// Backpressure throttles read issue via occupancy+in-flight credit; QEA_READER_EXEC_CYCLES_EN adds an o_exec_cycles counter.
module qea_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push_vld_i,
  input  logic [WIDTH-1:0]         push_dat_i,
  input  logic                     pop_i,
  output logic                     vld_o,
  output logic [WIDTH-1:0]         dat_o,
  output logic [$clog2(DEPTH):0]   cnt_o
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      cnt_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push_vld_i) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop_i)      rd_ptr_q <= rd_ptr_q + AW'(1);
      cnt_q <= cnt_q + (AW+1)'(push_vld_i) - (AW+1)'(pop_i);
    end
  end

  always_ff @(posedge clk) begin
    if (push_vld_i) mem_q[wr_ptr_q] <= push_dat_i;
  end

  // Storage is not reset, so the output is forced to zero while empty.
  assign vld_o = (cnt_q != '0);
  assign dat_o = vld_o ? mem_q[rd_ptr_q] : '0;
  assign cnt_o = cnt_q;
endmodule

module qea_state_reader #(
  parameter int PE_NUM           = 4,
  parameter int STATE_DATA_WIDTH = 64,
  parameter int STATE_ADDR_WIDTH = 16,
  parameter int MAX_QBIT_WIDTH   = 6,
  parameter int RD_LATENCY       = 1
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 i_arm,
  input  logic [MAX_QBIT_WIDTH-1:0]            i_qbit_num,
  input  logic                                 i_qea_start,
  input  logic                                 i_qea_complete,
  output logic [PE_NUM-1:0]                    o_state_ena,
  output logic [PE_NUM-1:0]                    o_state_wea,
  output logic [STATE_ADDR_WIDTH-1:0]          o_state_addra,
  input  logic [PE_NUM*STATE_DATA_WIDTH-1:0]   i_state_dout,
  output logic                                 o_valid,
  input  logic                                 i_ready,
  output logic [PE_NUM*STATE_DATA_WIDTH-1:0]   o_data,
  output logic                                 o_last,
  output logic                                 o_busy,
  output logic                                 o_done
`ifdef QEA_READER_EXEC_CYCLES_EN
  ,
  output logic [31:0]                          o_exec_cycles
`endif
);
  localparam int DW  = PE_NUM * STATE_DATA_WIDTH;
  localparam int SAW = STATE_ADDR_WIDTH;

  typedef enum logic [2:0] {IDLE, WAIT_CMPL, READ, DRAIN, DONE} state_t;

  state_t            state_q;
  logic [SAW-1:0]    last_addr_q, rd_addr_q, addr_q;
  logic              ena_q, last_issue_q, busy_q, done_q;
  logic [RD_LATENCY:1] pipe_vld_q, pipe_last_q;

  logic [2:0]        fifo_cnt;
  logic [DW:0]       fifo_dat;
  logic [3:0]        outstanding;
  logic              can_issue, pop, xfer_last;

  // Final address of the capture: depth 2^(q-2), depth 1 below q=2, clamped to the full RAM.
  function automatic logic [SAW-1:0] last_addr_of(input logic [MAX_QBIT_WIDTH-1:0] q);
    logic [SAW-1:0] one;
    one = SAW'(1);
    if (int'(q) < 2)                   return '0;
    else if (int'(q) - 2 >= SAW)       return '1;
    else                               return (one << (q - MAX_QBIT_WIDTH'(2))) - one;
  endfunction

  // The read issued this cycle (ena_q) and every pipeline stage each hold a FIFO slot.
  always_comb begin
    outstanding = 4'(fifo_cnt) + 4'(ena_q);
    for (int k = 1; k <= RD_LATENCY; k++) outstanding = outstanding + 4'(pipe_vld_q[k]);
  end

  assign can_issue = (outstanding < 4'd4);
  assign pop       = o_valid & i_ready;
  assign xfer_last = pop & o_last;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      last_addr_q  <= '0;
      rd_addr_q    <= '0;
      addr_q       <= '0;
      ena_q        <= 1'b0;
      last_issue_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      pipe_vld_q   <= '0;
      pipe_last_q  <= '0;
    end else begin
      ena_q          <= 1'b0;
      last_issue_q   <= 1'b0;
      done_q         <= 1'b0;
      pipe_vld_q[1]  <= ena_q;
      pipe_last_q[1] <= last_issue_q;
      for (int k = 2; k <= RD_LATENCY; k++) begin
        pipe_vld_q[k]  <= pipe_vld_q[k-1];
        pipe_last_q[k] <= pipe_last_q[k-1];
      end
      case (state_q)
        IDLE: begin
          if (i_arm) begin
            last_addr_q <= last_addr_of(i_qbit_num);
            rd_addr_q   <= '0;
            busy_q      <= 1'b1;
            state_q     <= WAIT_CMPL;
          end
        end
        WAIT_CMPL: begin
          if (i_qea_complete) state_q <= READ;
        end
        READ: begin
          if (can_issue) begin
            ena_q        <= 1'b1;
            addr_q       <= rd_addr_q;
            last_issue_q <= (rd_addr_q == last_addr_q);
            if (rd_addr_q == last_addr_q) state_q <= DRAIN;
            else                          rd_addr_q <= rd_addr_q + SAW'(1);
          end
        end
        DRAIN: begin
          if (xfer_last) begin
            done_q  <= 1'b1;
            state_q <= DONE;
          end
        end
        DONE: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  qea_fifo #(.WIDTH(DW + 1), .DEPTH(4)) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push_vld_i (pipe_vld_q[RD_LATENCY]),
    .push_dat_i ({pipe_last_q[RD_LATENCY], i_state_dout}),
    .pop_i      (pop),
    .vld_o      (o_valid),
    .dat_o      (fifo_dat),
    .cnt_o      (fifo_cnt)
  );

  assign o_data        = fifo_dat[DW-1:0];
  assign o_last        = fifo_dat[DW];
  assign o_state_ena   = {PE_NUM{ena_q}};
  assign o_state_wea   = '0;
  assign o_state_addra = addr_q;
  assign o_busy        = busy_q;
  assign o_done        = done_q;

`ifdef QEA_READER_EXEC_CYCLES_EN
  logic [31:0] exec_q;
  logic        exec_run_q;

  // The completion cycle itself is counted, then the value freezes.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      exec_q     <= '0;
      exec_run_q <= 1'b0;
    end else if (i_qea_start && (state_q == IDLE || state_q == WAIT_CMPL)) begin
      exec_q     <= '0;
      exec_run_q <= 1'b1;
    end else if (exec_run_q) begin
      if (exec_q != '1)   exec_q     <= exec_q + 32'd1;
      if (i_qea_complete) exec_run_q <= 1'b0;
    end
  end

  assign o_exec_cycles = exec_q;
`else
  logic unused_start;
  assign unused_start = i_qea_start;
`endif
endmodule

// File: tb/tb_qea_state_reader.sv
// Directed bench for qea_state_reader: three instances (latency 1, 3, 1) with address-tagged RAM models.
`timescale 1ns/1ps
module tb_qea_state_reader;
  localparam int PE = 4, SDW = 64, SAW = 16, MQW = 6, DW = PE * SDW;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic           arm [3];
  logic [MQW-1:0] qbit [3];
  logic           ready [3];
  logic           start, cmpl, bp_en;
  logic [PE-1:0]  ena [3], wea [3];
  logic [SAW-1:0] addra [3], a1 [3], a2 [3], a3 [3];
  logic [DW-1:0]  dout [3], data [3];
  logic           valid [3], last [3], busy [3], done [3];
`ifdef QEA_READER_EXEC_CYCLES_EN
  logic [31:0]    exec [3];
`endif

  function automatic logic [DW-1:0] word_of(input int a);
    logic [DW-1:0] w;
    logic [15:0]   a16;
    a16 = a[15:0];
    for (int i = 0; i < DW/32; i++) w[i*32 +: 32] = {a16, 8'(i), 8'hC3};
    return w;
  endfunction

  qea_state_reader #(.RD_LATENCY(1)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .i_arm(arm[0]), .i_qbit_num(qbit[0]),
    .i_qea_start(start), .i_qea_complete(cmpl), .o_state_ena(ena[0]),
    .o_state_wea(wea[0]), .o_state_addra(addra[0]), .i_state_dout(dout[0]),
    .o_valid(valid[0]), .i_ready(ready[0]), .o_data(data[0]), .o_last(last[0]),
`ifdef QEA_READER_EXEC_CYCLES_EN
    .o_exec_cycles(exec[0]),
`endif
    .o_busy(busy[0]), .o_done(done[0]));

  qea_state_reader #(.RD_LATENCY(3)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .i_arm(arm[1]), .i_qbit_num(qbit[1]),
    .i_qea_start(start), .i_qea_complete(cmpl), .o_state_ena(ena[1]),
    .o_state_wea(wea[1]), .o_state_addra(addra[1]), .i_state_dout(dout[1]),
    .o_valid(valid[1]), .i_ready(ready[1]), .o_data(data[1]), .o_last(last[1]),
`ifdef QEA_READER_EXEC_CYCLES_EN
    .o_exec_cycles(exec[1]),
`endif
    .o_busy(busy[1]), .o_done(done[1]));

  qea_state_reader #(.RD_LATENCY(1)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .i_arm(arm[2]), .i_qbit_num(qbit[2]),
    .i_qea_start(start), .i_qea_complete(cmpl), .o_state_ena(ena[2]),
    .o_state_wea(wea[2]), .o_state_addra(addra[2]), .i_state_dout(dout[2]),
    .o_valid(valid[2]), .i_ready(ready[2]), .o_data(data[2]), .o_last(last[2]),
`ifdef QEA_READER_EXEC_CYCLES_EN
    .o_exec_cycles(exec[2]),
`endif
    .o_busy(busy[2]), .o_done(done[2]));

  // RAM models: each word carries its own address.
  always @(posedge clk) begin
    for (int d = 0; d < 3; d++) begin
      a1[d] <= addra[d];
      a2[d] <= a1[d];
      a3[d] <= a2[d];
    end
  end
  assign dout[0] = word_of(int'(a1[0]));
  assign dout[1] = word_of(int'(a3[1]));
  assign dout[2] = word_of(int'(a1[2]));

  int n_chk = 0, n_pass = 0;

  task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  int cyc = 0;
  int issue_cnt [3], xfer_cnt [3], exp_words [3], data_err [3], last_err [3];
  int addr_err [3], wea_seen [3], stall_err [3], stall_seen [3], max_out [3];
  int done_cnt [3], done_err [3], last_xfer_cyc [3], first_issue [3], arm_cyc [3];
  logic          prev_stall [3], prev_last [3];
  logic [DW-1:0] prev_data [3];

  always @(negedge clk) begin
    cyc = cyc + 1;
    for (int d = 0; d < 3; d++) begin
      if (arm[d] === 1'b1 && busy[d] === 1'b0) arm_cyc[d] = cyc;
      if (wea[d] !== '0) wea_seen[d]++;
      if (ena[d] === '1) begin
        if (issue_cnt[d] == 0) first_issue[d] = cyc;
        if (int'(addra[d]) != issue_cnt[d]) addr_err[d]++;
        issue_cnt[d]++;
      end
      if (issue_cnt[d] - xfer_cnt[d] > max_out[d]) max_out[d] = issue_cnt[d] - xfer_cnt[d];
      if (prev_stall[d] && (valid[d] !== 1'b1 || data[d] !== prev_data[d] || last[d] !== prev_last[d]))
        stall_err[d]++;
      if (done[d] === 1'b1) begin
        done_cnt[d]++;
        if (cyc != last_xfer_cyc[d] + 1) done_err[d]++;
      end
      if (valid[d] === 1'b1 && ready[d] === 1'b1) begin
        if (data[d] !== word_of(xfer_cnt[d])) data_err[d]++;
        if (last[d] !== (xfer_cnt[d] == exp_words[d] - 1)) last_err[d]++;
        if (last[d] === 1'b1) last_xfer_cyc[d] = cyc;
        xfer_cnt[d]++;
      end
      prev_stall[d] = (valid[d] === 1'b1 && ready[d] === 1'b0);
      if (prev_stall[d]) stall_seen[d]++;
      prev_data[d] = data[d];
      prev_last[d] = last[d];
    end
  end

  // Ready toggles every cycle while backpressure is enabled.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      ready[1] = bp_en ? ~ready[1] : 1'b1;
    end
  end

  task automatic clear_mon(input int d, input int words);
    issue_cnt[d] = 0; xfer_cnt[d] = 0; exp_words[d] = words; data_err[d] = 0;
    last_err[d] = 0; addr_err[d] = 0; wea_seen[d] = 0; stall_err[d] = 0;
    stall_seen[d] = 0; max_out[d] = 0; done_cnt[d] = 0; done_err[d] = 0;
    last_xfer_cyc[d] = -10; first_issue[d] = -1; prev_stall[d] = 1'b0;
  endtask

  task automatic wait_done(input int d, input int budget, input string tag);
    int n = 0;
    while (done_cnt[d] == 0 && n < budget) begin
      @(posedge clk);
      n++;
    end
    chk({tag, "_in_budget"}, DW'(n < budget), DW'(1));
    repeat (3) @(posedge clk);
  endtask

  task automatic check_capture(input int d, input string tag);
    chk({tag, "_words"},    DW'(xfer_cnt[d]),  DW'(exp_words[d]));
    chk({tag, "_issues"},   DW'(issue_cnt[d]), DW'(exp_words[d]));
    chk({tag, "_data_err"}, DW'(data_err[d]),  DW'(0));
    chk({tag, "_last_err"}, DW'(last_err[d]),  DW'(0));
    chk({tag, "_addr_err"}, DW'(addr_err[d]),  DW'(0));
    chk({tag, "_done_cnt"}, DW'(done_cnt[d]),  DW'(1));
    chk({tag, "_done_lat"}, DW'(done_err[d]),  DW'(0));
    chk({tag, "_wea"},      DW'(wea_seen[d]),  DW'(0));
    chk({tag, "_idle"},     DW'(busy[d]),      DW'(0));
  endtask

  task automatic pulse_arm(input int d);
    @(posedge clk); #1 arm[d] = 1'b1;
    @(posedge clk); #1 arm[d] = 1'b0;
  endtask

  task automatic run_simple(input int d, input int q, input int words, input string tag);
    clear_mon(d, words);
    qbit[d] = MQW'(q);
    pulse_arm(d);
    wait_done(d, 2000, tag);
    check_capture(d, tag);
  endtask

  initial begin
    for (int d = 0; d < 3; d++) begin
      arm[d] = 1'b0; qbit[d] = '0; ready[d] = 1'b1;
      clear_mon(d, 0);
    end
    start = 1'b0; cmpl = 1'b0; bp_en = 1'b0;

    // Reset state, during reset and on the first cycle after it.
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ctl",  {ena[0], wea[0], addra[0], valid[0], last[0], busy[0], done[0]}, '0);
    chk("rst_data", data[0], '0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); @(negedge clk);
    chk("post_rst_ctl",  {ena[1], wea[1], addra[1], valid[1], last[1], busy[1], done[1]}, '0);
    chk("post_rst_data", data[1], '0);

    // Basic 16-qubit capture alongside a 20-qubit capture clamped to 65536 words.
    clear_mon(0, 16384);
    clear_mon(2, 65536);
    qbit[0] = 6'd16; qbit[2] = 6'd20;
    @(posedge clk); #1 arm[0] = 1'b1; arm[2] = 1'b1;
    @(posedge clk); #1 arm[0] = 1'b0; arm[2] = 1'b0;
    repeat (98) @(posedge clk);
    @(negedge clk);
    chk("wait_busy",      DW'(busy[0]),      DW'(1));
    chk("wait_no_issue",  DW'(issue_cnt[0]), DW'(0));
    @(posedge clk); #1 cmpl = 1'b1;
    wait_done(0, 17000, "basic");
    check_capture(0, "basic");
    wait_done(2, 70000, "q20");
    check_capture(2, "q20");

    // Backpressure with read latency 3.
    clear_mon(1, 4);
    qbit[1] = 6'd4;
    bp_en = 1'b1;
    pulse_arm(1);
    wait_done(1, 500, "bp");
    bp_en = 1'b0;
    check_capture(1, "bp");
    chk("bp_stable",    DW'(stall_err[1]),      DW'(0));
    chk("bp_stalled",   DW'(stall_seen[1] > 0), DW'(1));
    chk("bp_occupancy", DW'(max_out[1] <= 4),   DW'(1));

    // Edge depths.
    run_simple(0, 2, 1, "q2");
    run_simple(0, 1, 1, "q1");

    // Reset after 10 words of a 64-word capture.
    clear_mon(0, 64);
    qbit[0] = 6'd8;
    pulse_arm(0);
    begin
      int n = 0;
      while (xfer_cnt[0] < 10 && n < 500) begin
        @(posedge clk);
        n++;
      end
      chk("midrst_reach10", DW'(xfer_cnt[0] >= 10), DW'(1));
    end
    @(posedge clk); #1 rst_n = 1'b0;
    @(posedge clk); @(negedge clk);
    chk("midrst_ctl",  {ena[0], wea[0], addra[0], valid[0], last[0], busy[0], done[0]}, '0);
    chk("midrst_data", data[0], '0);
    @(posedge clk); #1 rst_n = 1'b1;
    clear_mon(0, 64);
    repeat (20) @(posedge clk);
    chk("midrst_no_words", DW'(xfer_cnt[0] + issue_cnt[0]), DW'(0));
    chk("midrst_no_done",  DW'(done_cnt[0]),                DW'(0));

    // Fresh arm with complete already high; arm pulses during READ are ignored.
    pulse_arm(0);
    qbit[0] = 6'd2;
    repeat (4) @(posedge clk);
    pulse_arm(0);
    repeat (3) @(posedge clk);
    pulse_arm(0);
    wait_done(0, 2000, "rearm");
    check_capture(0, "rearm");
    // One cycle in WAIT_CMPL, READ on the next, first read visible the cycle after.
    chk("cmpl_hi_lat", DW'(first_issue[0] - arm_cyc[0]), DW'(3));

`ifdef QEA_READER_EXEC_CYCLES_EN
    cmpl = 1'b0;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (522) @(posedge clk);
    #1 cmpl = 1'b1;
    @(posedge clk); @(negedge clk);
    chk("exec_523", DW'(exec[0]), DW'(523));
    repeat (10) @(posedge clk);
    @(negedge clk);
    chk("exec_hold", DW'(exec[0]), DW'(523));
    @(posedge clk); #1 cmpl = 1'b0; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    @(negedge clk);
    chk("exec_clear", DW'(exec[0]), DW'(0));
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/qea_state_reader.md
QEA_STATE_READER -- requirements
Module: qea_state_reader

Interface
REQ-001 The block SHALL have parameter PE_NUM, default 4, meaning the number of amplitude lanes per state RAM word.
REQ-002 The block SHALL have parameter STATE_DATA_WIDTH, default 64, meaning the width of one complex amplitude (32-bit real, 32-bit imaginary).
REQ-003 The block SHALL have parameter STATE_ADDR_WIDTH, default 16, meaning the state RAM address width.
REQ-004 The block SHALL have parameter MAX_QBIT_WIDTH, default 6, meaning the width of the qubit-count input.
REQ-005 The block SHALL have parameter RD_LATENCY, default 1, range 1..3, meaning the state RAM read latency in cycles.
REQ-006 The block SHALL have these ports:
- clk  in  1  clock; one clock only.
- rst_n  in  1  reset; synchronous, active-low.
- i_arm  in  1  pulse that arms a capture.
- i_qbit_num  in  MAX_QBIT_WIDTH  qubit count, sampled on i_arm.
- i_qea_start  in  1  the QEA start pulse, observed.
- i_qea_complete  in  1  the QEA completion level.
- o_state_ena  out  PE_NUM  state RAM enables.
- o_state_wea  out  PE_NUM  state RAM write enables.
- o_state_addra  out  STATE_ADDR_WIDTH  state RAM address.
- i_state_dout  in  PE_NUM*STATE_DATA_WIDTH  state RAM read data.
- o_valid  out  1  output stream valid.
- i_ready  in  1  output stream ready.
- o_data  out  PE_NUM*STATE_DATA_WIDTH  output word.
- o_last  out  1  marks the final word.
- o_busy  out  1  high when not IDLE.
- o_done  out  1  one-cycle pulse after the last word is accepted.

Function
REQ-007 The state machine SHALL have states IDLE, WAIT_CMPL, READ, DRAIN and DONE.
REQ-008 In IDLE, i_arm SHALL latch i_qbit_num and move to WAIT_CMPL.
REQ-009 In WAIT_CMPL, i_qea_complete=1 SHALL move to READ; this includes the case where complete is already high on the cycle after arm.
REQ-010 Depth SHALL be 2^(qbit_num-2) words.
REQ-011 A qbit_num below 2 SHALL give a depth of 1, and a qbit_num above STATE_ADDR_WIDTH+2 SHALL clamp the depth to 2^STATE_ADDR_WIDTH.
REQ-012 In READ, each issued read SHALL drive o_state_ena all ones, o_state_wea all zeros, and o_state_addra equal to the read counter, starting at 0 and incrementing by 1.
REQ-013 o_state_wea SHALL be zero in every state.
REQ-014 Read data SHALL be captured RD_LATENCY cycles after issue into an internal FIFO of depth 4.
REQ-015 A read SHALL be issued only when (FIFO occupancy + reads in flight) < 4, so that the FIFO never overflows.
REQ-016 After the read for address depth-1 has been issued, the FSM SHALL move to DRAIN, with no wrap of the address counter.
REQ-017 The output SHALL follow valid/ready rules:
- o_valid = FIFO not empty.
- Transfer on o_valid & i_ready.
- o_data and o_last SHALL hold stable while o_valid=1 and i_ready=0.
REQ-018 o_last SHALL be 1 only on the word from address depth-1.
REQ-019 When the o_last word is transferred, the FSM SHALL move to DONE, which pulses o_done for one cycle and returns to IDLE.
REQ-020 i_arm SHALL be ignored outside IDLE.
REQ-021 A deassertion of i_qea_complete during READ or DRAIN SHALL be ignored.
REQ-022 When a FIFO push and pop occur in the same cycle, occupancy SHALL be unchanged and word order SHALL be preserved.
REQ-023 o_busy SHALL be 1 in every state except IDLE.

Reset
REQ-024 rst_n=0 at any clock edge SHALL force IDLE, empty the FIFO, discard in-flight reads and clear the counters.
REQ-025 While reset is applied and on the first cycle after it, o_state_ena, o_state_wea, o_state_addra, o_valid, o_data, o_last, o_busy and o_done SHALL all be 0.
REQ-026 A reset in the middle of a capture SHALL abort it without an o_done pulse, and no word SHALL be emitted afterwards.

Configuration
REQ-027 With macro QEA_READER_EXEC_CYCLES_EN defined, the block SHALL add output o_exec_cycles (32 bits, reset 0) that counts clk cycles:
- It clears and starts on i_qea_start=1 in IDLE or WAIT_CMPL.
- It stops on the first cycle i_qea_complete=1.
- It holds its value until the next start.
- It saturates at 2^32-1.
REQ-028 Without QEA_READER_EXEC_CYCLES_EN, the port and the counter SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-029 Scenario, basic capture: arm with qbit_num=16, RD_LATENCY=1, i_ready=1, complete raised 100 cycles later -> 16384 words on addresses 0..16383 in order, o_last on word 16383, o_done 1 cycle later, and o_state_wea never 1.
REQ-030 Scenario, backpressure: qbit_num=4 (4 words), i_ready toggling 1/0 each cycle, RD_LATENCY=3 -> exactly 4 words, no loss or duplication, o_data stable during stalls, and FIFO occupancy never above 4.
REQ-031 Scenario, edge depths: qbit_num=2 -> 1 word with o_last=1; qbit_num=1 -> 1 word; qbit_num=20 -> 65536 words, with address 65535 last and no wrap to 0.
REQ-032 Scenario, reset mid-read: rst_n=0 after 10 words of a 64-word capture -> all outputs 0 next cycle, no o_done, and a fresh arm restarts at address 0.
REQ-033 Scenario, complete already high: complete held at 1 before arm -> READ entered 1 cycle after arm; i_arm pulses during READ are ignored.
REQ-034 Scenario, macro defined: start pulse, then complete 523 cycles later -> o_exec_cycles = 523 and held; a second start clears it to 0.
